// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM encoding and PC step.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DROP   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INC = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, npc} holding register for a fetch that lands during a stall.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  push,
  input  logic  pop,
  input  logic  clear,
  input  word_t push_instr,
  input  word_t push_npc,
  output logic  full,
  output word_t instr,
  output word_t npc
);

  // clear wins over push so a flush/redirect never leaves a stale entry
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full  <= 1'b0;
      instr <= '0;
      npc   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= push_instr;
      npc   <= push_npc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, redirect drop handling and halt.
// Optional skid buffer for fetches returning during a stall: FETCH_SKID_EN.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         ihit,
  input  word_t        iload,
  output logic         imemREN,
  output logic [31:0]  imemaddr,
  input  logic         stall,
  input  logic         flush,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         halt,
  output logic [31:0]  instr,
  output logic [31:0]  npc,
  output logic         valid,
  output fetch_state_t fsm_state
);

  // Handshake: imemREN=1 holds a read of imemaddr open; a cycle with ihit=1
  // completes it with iload, and no other cycle transfers data.

  fetch_state_t state, state_n;
  word_t pc, pc_n, old_pc, old_pc_n, target, target_n;
  word_t instr_n, npc_n;
  logic  valid_n;
  logic  skid_full;

`ifdef FETCH_SKID_EN
  logic  skid_push, skid_pop, skid_clear;
  word_t skid_instr, skid_npc;

  fetch_skid_buf u_skid (
    .CLK        (CLK),
    .nRST       (nRST),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .push_instr (iload),
    .push_npc   (pc + PC_INC),
    .full       (skid_full),
    .instr      (skid_instr),
    .npc        (skid_npc)
  );
`else
  assign skid_full = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= FETCH;
      pc     <= PC_INIT;
      old_pc <= PC_INIT;
      target <= PC_INIT;
      instr  <= '0;
      npc    <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      old_pc <= old_pc_n;
      target <= target_n;
      instr  <= instr_n;
      npc    <= npc_n;
      valid  <= valid_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    old_pc_n = old_pc;
    target_n = target;
    instr_n  = instr;
    npc_n    = npc;
    valid_n  = valid;
`ifdef FETCH_SKID_EN
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
`endif
    case (state)
      HALTED: ;
      default: begin
        if (halt) begin
          state_n = HALTED;
          valid_n = 1'b0;
`ifdef FETCH_SKID_EN
          skid_clear = 1'b1;
`endif
        end else if (state == DROP) begin
          // the in-flight read of old_pc must return before the new target is issued
          if (redirect) target_n = redirect_pc;
          if (flush) begin
            valid_n = 1'b0;
            instr_n = '0;
          end
          if (ihit) begin
            pc_n    = redirect ? redirect_pc : target;
            state_n = FETCH;
          end
        end else if (redirect) begin
`ifdef FETCH_SKID_EN
          skid_clear = 1'b1;
`endif
          if (ihit) begin
            pc_n = redirect_pc;
          end else begin
            old_pc_n = pc;
            target_n = redirect_pc;
            state_n  = DROP;
          end
        end else if (flush) begin
          valid_n = 1'b0;
          instr_n = '0;
`ifdef FETCH_SKID_EN
          skid_clear = 1'b1;
`endif
        end else if (stall) begin
`ifdef FETCH_SKID_EN
          if (ihit && !skid_full) begin
            skid_push = 1'b1;
            pc_n      = pc + PC_INC;
          end
`endif
        end else begin
`ifdef FETCH_SKID_EN
          if (skid_full) begin
            instr_n  = skid_instr;
            npc_n    = skid_npc;
            valid_n  = 1'b1;
            skid_pop = 1'b1;
          end else
`endif
          if (ihit) begin
            instr_n = iload;
            npc_n   = pc + PC_INC;
            valid_n = 1'b1;
            pc_n    = pc + PC_INC;
          end
        end
      end
    endcase
  end

  assign imemREN   = nRST && (state != HALTED) && !skid_full;
  assign imemaddr  = !nRST ? PC_INIT : ((state == DROP) ? old_pc : pc);
  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (honours FETCH_SKID_EN).
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic         CLK;
  logic         nRST;
  logic         ihit;
  word_t        iload;
  logic         imemREN;
  logic [31:0]  imemaddr;
  logic         stall;
  logic         flush;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         halt;
  logic [31:0]  instr;
  logic [31:0]  npc;
  logic         valid;
  fetch_state_t fsm_state;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr       (instr),
    .npc         (npc),
    .valid       (valid),
    .fsm_state   (fsm_state)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; iload = 32'h2002_0005;
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #1;
    chk("rst_ren",   {31'd0, imemREN}, 32'd0);
    chk("rst_addr",  imemaddr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_npc",   npc, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);

    @(negedge CLK); nRST = 1'b1; #1;
    chk("rel_addr", imemaddr, 32'h0);
    chk("rel_ren",  {31'd0, imemREN}, 32'd1);
    @(negedge CLK);
    chk("f1_instr", instr, 32'h2002_0005);
    chk("f1_npc",   npc, 32'h4);
    chk("f1_valid", {31'd0, valid}, 32'd1);
    chk("f1_addr",  imemaddr, 32'h4);

    // stall with ihit held
    stall = 1'b1; iload = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stl_instr", instr, 32'h2002_0005);
`ifdef FETCH_SKID_EN
      chk("stl_addr", imemaddr, 32'h8);
      chk("stl_ren",  {31'd0, imemREN}, 32'd0);
`else
      chk("stl_addr", imemaddr, 32'h4);
`endif
    end
    stall = 1'b0;
    @(negedge CLK);
    chk("unstl_instr", instr, 32'h1111_1111);
    chk("unstl_npc",   npc, 32'h8);
    chk("unstl_addr",  imemaddr, 32'h8);
    chk("unstl_ren",   {31'd0, imemREN}, 32'd1);

    // redirect while no ihit -> DROP
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("rd_pre_addr", imemaddr, 32'h8);
    @(negedge CLK);
    chk("drop_state", 32'(fsm_state), 32'(DROP));
    chk("drop_addr",  imemaddr, 32'h8);
    chk("drop_ren",   {31'd0, imemREN}, 32'd1);
    redirect = 1'b0; ihit = 1'b1; iload = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("drop_done_addr",  imemaddr, 32'h100);
    chk("drop_done_instr", instr, 32'h1111_1111);
    chk("drop_done_state", 32'(fsm_state), 32'(FETCH));
    @(negedge CLK);
    chk("tgt_instr", instr, 32'hDEAD_BEEF);
    chk("tgt_npc",   npc, 32'h104);
    chk("tgt_addr",  imemaddr, 32'h104);

    // redirect coincident with ihit
    redirect = 1'b1; redirect_pc = 32'h200; iload = 32'h55;
    @(negedge CLK);
    chk("rdh_addr",  imemaddr, 32'h200);
    chk("rdh_instr", instr, 32'hDEAD_BEEF);
    chk("rdh_state", 32'(fsm_state), 32'(FETCH));

    // flush overrides stall
    redirect = 1'b0; flush = 1'b1; stall = 1'b1;
    @(negedge CLK);
    chk("fl_valid", {31'd0, valid}, 32'd0);
    chk("fl_instr", instr, 32'h0);
    chk("fl_addr",  imemaddr, 32'h200);

    // PC wrap
    flush = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge CLK);
    chk("wrap_pre_addr", imemaddr, 32'hFFFF_FFFC);
    redirect = 1'b0; iload = 32'h33;
    @(negedge CLK);
    chk("wrap_instr", instr, 32'h33);
    chk("wrap_npc",   npc, 32'h0);
    chk("wrap_valid", {31'd0, valid}, 32'd1);
    chk("wrap_addr",  imemaddr, 32'h0);

    // halt is sticky until reset
    halt = 1'b1;
    @(negedge CLK);
    chk("halt_ren",   {31'd0, imemREN}, 32'd0);
    chk("halt_valid", {31'd0, valid}, 32'd0);
    chk("halt_state", 32'(fsm_state), 32'(HALTED));
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h400; iload = 32'h77;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("hold_ren",   {31'd0, imemREN}, 32'd0);
      chk("hold_addr",  imemaddr, 32'h0);
      chk("hold_instr", instr, 32'h33);
      chk("hold_valid", {31'd0, valid}, 32'd0);
    end

    // reset out of HALTED
    redirect = 1'b0; nRST = 1'b0; #1;
    chk("rst2_addr",  imemaddr, 32'h0);
    chk("rst2_ren",   {31'd0, imemREN}, 32'd0);
    chk("rst2_instr", instr, 32'h0);
    chk("rst2_state", 32'(fsm_state), 32'(FETCH));
    @(negedge CLK); nRST = 1'b1; iload = 32'h99;
    @(negedge CLK);
    chk("rst2_f_instr", instr, 32'h99);
    chk("rst2_f_npc",   npc, 32'h4);

    // reset abandons a pending DROP
    ihit = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
    @(negedge CLK);
    chk("rdrop_state", 32'(fsm_state), 32'(DROP));
    chk("rdrop_addr",  imemaddr, 32'h4);
    redirect = 1'b0; nRST = 1'b0; #1;
    chk("rdrop_rst_addr",  imemaddr, 32'h0);
    chk("rdrop_rst_state", 32'(fsm_state), 32'(FETCH));
    @(negedge CLK); nRST = 1'b1; ihit = 1'b1; iload = 32'hAA; #1;
    chk("rdrop_rel_addr", imemaddr, 32'h0);
    @(negedge CLK);
    chk("rdrop_f_instr", instr, 32'hAA);
    chk("rdrop_f_npc",   npc, 32'h4);
    chk("rdrop_f_addr",  imemaddr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
